// File: rtl/matrix_mac_engine_pkg.sv
// matrix_mac_engine_pkg: Q-format constants, round/saturate helper and latched op type
package matrix_mac_engine_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;
    localparam int RS_W       = 64;

    localparam logic signed [DATA_WIDTH-1:0] FP_ZERO    = '0;
    localparam logic signed [DATA_WIDTH-1:0] FP_MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] FP_MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [RS_W-1:0]       RND_HALF   = RS_W'(1) << (FRAC_BITS - 1);

    typedef struct packed {
        logic trans_b;
        logic acc;
        logic neg;
    } mac_op_t;

    function automatic logic [DATA_WIDTH:0] fp_round_sat(input logic signed [RS_W-1:0] acc);
        logic signed [RS_W-1:0] r;
        r = (acc + RND_HALF) >>> FRAC_BITS;
        return r > RS_W'(FP_MAX_POS) ? {1'b1, FP_MAX_POS}
             : r < RS_W'(FP_MIN_NEG) ? {1'b1, FP_MIN_NEG}
             : {1'b0, r[DATA_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/matrix_mac_engine_if.sv
// matrix_mac_engine_if: command/operand/result bundle; sat_count exists only with `MATRIX_MAC_SAT_COUNT_EN
interface matrix_mac_engine_if
    import matrix_mac_engine_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 4,
    parameter int P = 4
);
    logic start, op_trans_b, op_acc, op_neg;
    logic busy, done, sat_flag;
    logic [N*M-1:0][DATA_WIDTH-1:0] matrix_a;
    logic [M*P-1:0][DATA_WIDTH-1:0] matrix_b;
    logic [N*P-1:0][DATA_WIDTH-1:0] matrix_c_in;
    logic [N*P-1:0][DATA_WIDTH-1:0] matrix_c;
`ifdef MATRIX_MAC_SAT_COUNT_EN
    logic [$clog2(N*P+1)-1:0] sat_count;
    modport master (output start, op_trans_b, op_acc, op_neg, matrix_a, matrix_b, matrix_c_in,
                    input busy, done, sat_flag, matrix_c, sat_count);
    modport slave  (input start, op_trans_b, op_acc, op_neg, matrix_a, matrix_b, matrix_c_in,
                    output busy, done, sat_flag, matrix_c, sat_count);
`else
    modport master (output start, op_trans_b, op_acc, op_neg, matrix_a, matrix_b, matrix_c_in,
                    input busy, done, sat_flag, matrix_c);
    modport slave  (input start, op_trans_b, op_acc, op_neg, matrix_a, matrix_b, matrix_c_in,
                    output busy, done, sat_flag, matrix_c);
`endif
endinterface

// File: rtl/matrix_mac_engine_mac_lane.sv
// mac_lane: one output column MAC with clear/preload, +/- accumulate and round/saturate
module mac_lane
    import matrix_mac_engine_pkg::*;
#(
    parameter int M = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         pre_en_i,
    input  logic                         en_i,
    input  logic                         neg_i,
    input  logic signed [DATA_WIDTH-1:0] pre_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] res_o,
    output logic                         sat_o
);
    localparam int AW = 2 * DATA_WIDTH + $clog2(M) + 1;

    logic signed [AW-1:0] acc_q, acc_d, prod;

    // next accumulator value and rounded/saturated view of the current one
    always_comb begin
        prod = AW'(a_i) * AW'(b_i);
        acc_d = clr_i ? (pre_en_i ? AW'(pre_i) <<< FRAC_BITS : '0)
              : en_i ? (neg_i ? acc_q - prod : acc_q + prod) : acc_q;
        {sat_o, res_o} = fp_round_sat(RS_W'(acc_q));
    end

    // accumulator register
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else acc_q <= acc_d;
    end

endmodule

// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: fixed-point GEMM C = sat(Cin*acc +/- A*op(B)) over LANES columns at a time; `MATRIX_MAC_SAT_COUNT_EN adds sat_count
module matrix_mac_engine
    import matrix_mac_engine_pkg::*;
#(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int P     = 4,
    parameter int LANES = 2
) (
    input logic                clk,
    input logic                rst,
    matrix_mac_engine_if.slave bus
);
    localparam int G  = (P + LANES - 1) / LANES;
    localparam int RW = $clog2(N + 1);
    localparam int GW = $clog2(G + 1);
    localparam int KW = $clog2(M + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                     state_q, state_d;
    logic [RW-1:0]                  row_q;
    logic [GW-1:0]                  grp_q;
    logic [KW-1:0]                  k_q;
    logic                           busy_q, done_q, sat_q, sat_any;
    logic                           last_grp, last_row, accept;
    mac_op_t                        op_q;
    logic [N*P-1:0][DATA_WIDTH-1:0] c_q;
    logic [DATA_WIDTH-1:0]          a_l;
    logic [DATA_WIDTH-1:0]          b_l   [LANES];
    logic [DATA_WIDTH-1:0]          pre_l [LANES];
    logic [DATA_WIDTH-1:0]          res_l [LANES];
    logic                           vld_l [LANES];
    logic                           sat_l [LANES];
    int                             idx_l [LANES];

    assign accept   = state_q == S_IDLE && bus.start;
    assign last_grp = grp_q == GW'(G - 1);
    assign last_row = row_q == RW'(N - 1);

    // operand selection per lane; out-of-range columns are clamped for reading and masked for writing
    always_comb begin
        a_l = bus.matrix_a[int'(row_q) * M + int'(k_q)];
        for (int l = 0; l < LANES; l++) begin
            automatic int col = int'(grp_q) * LANES + l;
            automatic int cc  = (col < P) ? col : P - 1;
            vld_l[l] = col < P;
            idx_l[l] = int'(row_q) * P + cc;
            b_l[l]   = op_q.trans_b ? bus.matrix_b[cc * M + int'(k_q)] : bus.matrix_b[int'(k_q) * P + cc];
            pre_l[l] = bus.matrix_c_in[idx_l[l]];
        end
    end

    // any unmasked lane saturating in this group
    always_comb begin
        sat_any = 1'b0;
        for (int l = 0; l < LANES; l++) sat_any = sat_any | (vld_l[l] & sat_l[l]);
    end

    // FSM: one LOAD, M MAC cycles and one WRITE per column group
    always_comb begin
        state_d = state_q == S_IDLE  ? (bus.start ? S_LOAD : S_IDLE)
                : state_q == S_LOAD  ? S_MAC
                : state_q == S_MAC   ? (k_q == KW'(M - 1) ? S_WRITE : S_MAC)
                : state_q == S_WRITE ? (last_grp && last_row ? S_DONE : S_LOAD)
                : S_IDLE;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(.M(M)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (state_q == S_LOAD),
            .pre_en_i(op_q.acc),
            .en_i    (state_q == S_MAC),
            .neg_i   (op_q.neg),
            .pre_i   (pre_l[i]),
            .a_i     (a_l),
            .b_i     (b_l[i]),
            .res_o   (res_l[i]),
            .sat_o   (sat_l[i])
        );
    end

    // state, counters, latched op, result store and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            grp_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            op_q    <= '0;
            c_q     <= {(N*P){FP_ZERO}};
        end else begin
            state_q <= state_d;
            done_q  <= state_q == S_DONE;
            if (accept) begin
                op_q   <= '{trans_b: bus.op_trans_b, acc: bus.op_acc, neg: bus.op_neg};
                busy_q <= 1'b1;
                sat_q  <= 1'b0;
                row_q  <= '0;
                grp_q  <= '0;
            end
            if (state_q == S_LOAD) k_q <= '0;
            if (state_q == S_MAC) k_q <= k_q + KW'(1);
            if (state_q == S_WRITE) begin
                grp_q <= last_grp ? '0 : grp_q + GW'(1);
                row_q <= last_grp ? row_q + RW'(1) : row_q;
                sat_q <= sat_q | sat_any;
                for (int l = 0; l < LANES; l++)
                    if (vld_l[l]) c_q[idx_l[l]] <= res_l[l];
            end
            if (state_q == S_DONE) busy_q <= 1'b0;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sat_flag = sat_q;
    assign bus.matrix_c = c_q;

`ifdef MATRIX_MAC_SAT_COUNT_EN
    localparam int CW = $clog2(N * P + 1);
    logic [CW-1:0] cnt_q, sat_add;

    // number of unmasked lanes saturating in this group
    always_comb begin
        sat_add = '0;
        for (int l = 0; l < LANES; l++) sat_add = sat_add + CW'(vld_l[l] & sat_l[l]);
    end

    // saturated-element counter for the current op
    always_ff @(posedge clk) begin
        if (rst || accept) cnt_q <= '0;
        else if (state_q == S_WRITE) cnt_q <= cnt_q + sat_add;
    end

    assign bus.sat_count = cnt_q;
`endif

endmodule
